ysyx_23060201_idu: RTL
======================

// Module: ysyx_23060201_idu
// PURPOSE
//   Instruction decode stage directly downstream of the fetch unit. Accepts {pc, inst} from fetch over a
//   valid/ready handshake, buffers up to 2 entries, decodes RV32I fields and the immediate at enqueue,
//   and presents a registered decode bundle to the execute stage over a second valid/ready handshake.
// PARAMETERS
//   MEM_ADDR_WIDTH  32  width of pc
//   DATA_WIDTH      32  width of instruction and immediate
//   DEPTH           2   buffer entries; fixed at 2 for this revision (skid buffer)
// PORTS
//   clk         in   1   single clock, rising edge
//   rst         in   1   asynchronous, active-low reset
//   flush       in   1   redirect from execute; discards all buffered entries
//   in_valid    in   1   fetch presents pc/inst
//   in_ready    out  1   buffer can accept this cycle
//   in_pc       in   MEM_ADDR_WIDTH  pc of fetched instruction
//   in_inst     in   DATA_WIDTH      fetched instruction word
//   out_valid   out  1   decode bundle valid
//   out_ready   in   1   execute consumes bundle
//   out_pc      out  MEM_ADDR_WIDTH  pc of head entry
//   out_inst    out  DATA_WIDTH      raw instruction of head entry
//   out_rd/out_rs1/out_rs2  out  5   register indices (inst[11:7]/[19:15]/[24:20])
//   out_imm     out  DATA_WIDTH      sign-extended immediate per format
//   out_fmt     out  3   format: R,I,S,B,U,J,N (encodings in defines.v)
//   out_illegal out  1   illegal-instruction flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst=0, async): count=0, rd/wr ptr=0, in_ready=1, out_valid=0, all out_* data = 0.
//   - Enqueue when in_valid&in_ready&!flush; dequeue when out_valid&out_ready.
//   - in_ready = (count<2); registered state only, never combinationally depends on out_ready.
//   - out_valid = (count!=0); out_* driven from head entry storage, no comb path from in_* to out_*.
//   - Latency: entry accepted in cycle N visible at out_valid in cycle N+1 at earliest.
//   - count=1 with enq+deq same cycle: count stays 1, new entry becomes head next cycle.
//   - count=2: in_ready=0; a deq that cycle frees a slot, in_ready=1 next cycle.
//   - flush: count<=0, ptrs<=0 next edge; enqueue in same cycle is dropped; out_valid=0 next cycle.
//   - Pointers 1-bit, wrap 1->0. Data outputs hold last head value when out_valid=0.
//   - Decode by opcode inst[6:0]: LUI/AUIPC->U, JAL->J, JALR/LOAD/OP-IMM->I, STORE->S, BRANCH->B,
//     OP->R, SYSTEM and all others->N. Imm: I {20{i31},i[31:20]}; S {20{i31},i[31:25],i[11:7]};
//     B {19{i31},i31,i7,i[30:25],i[11:8],0}; U {i[31:12],12'b0}; J {11{i31},i31,i[19:12],i20,i[30:21],0};
//     R/N imm=0. rd/rs1/rs2 always raw bit slices regardless of format.
// CONFIGURATION
//   YSYX_IDU_ILLEGAL_CHECK_EN defined: out_illegal=1 when inst[1:0]!=2'b11 or opcode not in
//     {LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP-IMM,OP,SYSTEM}; flag stored per entry, bundle still passes.
//   Undefined: out_illegal tied 0, no illegal storage bits; unknown opcodes decode as N, imm=0.
// STRUCTURE
//   defines.v: opcode constants, FMT_* encodings, `MBASE.
//   Sub-module ysyx_23060201_immgen: combinational inst->{fmt, imm}, instantiated once at enqueue path.
//   Top: 2-entry storage array, ptrs, count, handshake logic.
// TESTING
//   1. in 0x00500093 (addi x1,x0,5) pc=0x80000000, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, fmt=I.
//   2. in 0x123452B7 (lui x5) -> rd=5, imm=0x12345000, fmt=U.
//   3. in 0xFE20AE23 (sw x2,-4(x1)) -> rs1=1, rs2=2, imm=0xFFFFFFFC, fmt=S.
//   4. out_ready=0, push 3 back-to-back -> in_ready=0 after 2nd accept; release -> order pc0,pc1,pc2 preserved.
//   5. count=2, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; dropped entry never appears.
//   6. with YSYX_IDU_ILLEGAL_CHECK_EN, in 0x00000000 -> out_illegal=1; 0x00100073 -> illegal=0, fmt=N; rst low mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/ysyx_23060201_idu_pkg.sv
// Shared decode-stage types: opcodes, format codes, buffer entry layout.
// YSYX_IDU_ILLEGAL_CHECK_EN adds a per-entry illegal flag.
package ysyx_23060201_idu_pkg;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_N = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
    fmt_e          fmt;
    logic [DW-1:0] imm;
`ifdef YSYX_IDU_ILLEGAL_CHECK_EN
    logic          ill;
`endif
  } entry_t;

  function automatic logic is_known_op(
    input logic [6:0] op
  );
    return op inside {
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BRANCH, OP_LOAD, OP_STORE,
      OP_OPIMM, OP_OP, OP_SYSTEM
    };
  endfunction

endpackage

// File: rtl/ysyx_23060201_idu_immgen.sv
// Combinational RV32I format classifier and immediate builder.
// YSYX_IDU_ILLEGAL_CHECK_EN adds the illegal output.
module ysyx_23060201_immgen
  import ysyx_23060201_idu_pkg::*;
(
  input  logic [DW-1:0] inst,
  output fmt_e          fmt,
`ifdef YSYX_IDU_ILLEGAL_CHECK_EN
  output logic          illegal,
`endif
  output logic [DW-1:0] imm
);

  logic [6:0] op;

  assign op = inst[6:0];

  // Pick format from opcode and assemble the sign-extended immediate.
  always_comb begin
    fmt = FMT_N;
    imm = '0;
    unique case (1'b1)
      (op == OP_LUI) || (op == OP_AUIPC): begin
        fmt = FMT_U;
        imm = {inst[31:12], 12'b0};
      end
      (op == OP_JAL): begin
        fmt = FMT_J;
        imm = {{11{inst[31]}}, inst[31],
               inst[19:12], inst[20],
               inst[30:21], 1'b0};
      end
      (op == OP_JALR) || (op == OP_LOAD) ||
      (op == OP_OPIMM): begin
        fmt = FMT_I;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      (op == OP_STORE): begin
        fmt = FMT_S;
        imm = {{20{inst[31]}},
               inst[31:25], inst[11:7]};
      end
      (op == OP_BRANCH): begin
        fmt = FMT_B;
        imm = {{19{inst[31]}}, inst[31],
               inst[7], inst[30:25],
               inst[11:8], 1'b0};
      end
      (op == OP_OP): begin
        fmt = FMT_R;
      end
      default: begin
        fmt = FMT_N;
      end
    endcase
  end

`ifdef YSYX_IDU_ILLEGAL_CHECK_EN
  // Low bits must mark a 32-bit encoding and the opcode must be known.
  always_comb begin
    illegal = (inst[1:0] != 2'b11) ||
              !is_known_op(op);
  end
`endif

endmodule

// File: rtl/ysyx_23060201_idu.sv
// Decode stage: 2-entry skid buffer, decode at enqueue, registered head.
// YSYX_IDU_ILLEGAL_CHECK_EN stores and reports an illegal flag.
module ysyx_23060201_idu
  import ysyx_23060201_idu_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MEM_ADDR_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0]     in_inst,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MEM_ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0]     out_inst,
  output logic [4:0]                out_rd,
  output logic [4:0]                out_rs1,
  output logic [4:0]                out_rs2,
  output logic [DATA_WIDTH-1:0]     out_imm,
  output logic [2:0]                out_fmt,
  output logic                      out_illegal
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  entry_t        mem_q [2];
  entry_t        mem_d [2];
  entry_t        out_q;
  entry_t        out_d;
  entry_t        new_ent;
  logic          wr_q;
  logic          wr_d;
  logic          rd_q;
  logic          rd_d;
  logic [1:0]    cnt_q;
  logic [1:0]    cnt_d;
  logic          enq;
  logic          deq;
  fmt_e          dec_fmt;
  logic [DW-1:0] dec_imm;
`ifdef YSYX_IDU_ILLEGAL_CHECK_EN
  logic          dec_ill;
`endif

  ysyx_23060201_immgen u_immgen (
    .inst    (in_inst),
    .fmt     (dec_fmt),
`ifdef YSYX_IDU_ILLEGAL_CHECK_EN
    .illegal (dec_ill),
`endif
    .imm     (dec_imm)
  );

  // Handshakes come only from registered occupancy.
  always_comb begin
    in_ready  = (cnt_q < FULL);
    out_valid = (cnt_q != 2'd0);
    enq       = in_valid && in_ready && !flush;
    deq       = out_valid && out_ready;
  end

  // Bundle the incoming word with its decode.
  always_comb begin
    new_ent      = '0;
    new_ent.pc   = in_pc;
    new_ent.inst = in_inst;
    new_ent.fmt  = dec_fmt;
    new_ent.imm  = dec_imm;
`ifdef YSYX_IDU_ILLEGAL_CHECK_EN
    new_ent.ill  = dec_ill;
`endif
  end

  // Next buffer state; head register follows the new head or holds.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    out_d = out_q;
    if (flush) begin
      wr_d  = 1'b0;
      rd_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (enq) begin
        mem_d[wr_q] = new_ent;
        wr_d        = ~wr_q;
      end
      if (deq) begin
        rd_d = ~rd_q;
      end
      cnt_d = cnt_q + {1'b0, enq} - {1'b0, deq};
      if (cnt_d != 2'd0) begin
        out_d = mem_d[rd_d];
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
      out_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  // Field slices come straight from the registered head.
  always_comb begin
    out_pc   = out_q.pc;
    out_inst = out_q.inst;
    out_rd   = out_q.inst[11:7];
    out_rs1  = out_q.inst[19:15];
    out_rs2  = out_q.inst[24:20];
    out_imm  = out_q.imm;
    out_fmt  = out_q.fmt;
`ifdef YSYX_IDU_ILLEGAL_CHECK_EN
    out_illegal = out_q.ill;
`else
    out_illegal = 1'b0;
`endif
  end

endmodule
